// File: rtl/fpu_mc.sv
// fpu_mc: multi-cycle minifloat unit, {sign, exp, mant} words, truncating.
// Ports: clk, reset (async, active-low), start/op/op1/op2 request;
//        result/ovf/inv held results, busy while working, done one-cycle pulse.
module fpu_mc #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 7,
    parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4:0]              op,
    input  logic [EXP_W+MANT_W:0]   op1,
    input  logic [EXP_W+MANT_W:0]   op2,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic                    inv
);

    localparam int W    = 1 + EXP_W + MANT_W;
    localparam int MW   = MANT_W + 1;
    localparam int AW_A = (W > 2 * MW) ? W : 2 * MW;
    localparam int AW   = (AW_A > MW + 3) ? AW_A : MW + 3;
    localparam int LZW  = $clog2(AW + 1);
    localparam int XW   = EXP_W + 3;
    localparam int SW   = W + MW;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic signed [XW-1:0] XBIAS = XW'(BIAS);
    localparam logic signed [XW-1:0] XEMAX = XW'(EMAX);
    localparam logic signed [XW-1:0] XWM1  = XW'(W - 1);
    localparam logic signed [XW-1:0] XONE  = XW'(1);

    localparam logic [4:0] OP_ITOF = 5'b10010;
    localparam logic [4:0] OP_FTOI = 5'b10011;
    localparam logic [4:0] OP_MULF = 5'b10101;
    localparam logic [4:0] OP_SUBF = 5'b10110;
    localparam logic [4:0] OP_ADDF = 5'b10111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_EXEC,
        S_NORM,
        S_PACK
    } state_t;

    state_t state_q;

    logic [4:0]   op_q;
    logic [W-1:0] a_q, b_q;

    logic             s1_q, s2_q;
    logic [EXP_W-1:0] e1_q, e2_q;
    logic [MW-1:0]    m1_q, m2_q;

    logic                 sgn_q;
    logic [AW-1:0]        acc_q;
    logic signed [XW-1:0] exp_q;
    logic                 direct_q;
    logic [W-1:0]         dres_q;
    logic                 dovf_q, dinv_q;

    logic [MW-1:0]        nman_q;
    logic signed [XW-1:0] nexp_q;

    logic [W-1:0] result_q;
    logic         busy_q, done_q, ovf_q, inv_q;

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign inv    = inv_q;

    function automatic logic [LZW-1:0] lzc(input logic [AW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(AW);
        for (int i = 0; i < AW; i++) begin
            if (v[i]) n = LZW'(AW - 1 - i);
        end
        return n;
    endfunction

    // ---------------- unpack ----------------
    logic [EXP_W-1:0] u_e1, u_e2;
    logic [MW-1:0]    u_m1, u_m2;
    logic             u_s2;

    always_comb begin
        u_e1 = a_q[W-2 -: EXP_W];
        u_e2 = b_q[W-2 -: EXP_W];
        // Exponent field 0 means zero: drop the hidden one and the fraction.
        u_m1 = (u_e1 == '0) ? '0 : {1'b1, a_q[MANT_W-1:0]};
        u_m2 = (u_e2 == '0) ? '0 : {1'b1, b_q[MANT_W-1:0]};
        u_s2 = b_q[W-1] ^ (op_q == OP_SUBF);
    end

    // ---------------- execute ----------------
    logic signed [XW-1:0] x1, x2, xb, ft_k;
    logic                 a_ge, add_sb, add_bypass;
    logic [EXP_W-1:0]     add_eb, add_es, add_diff;
    logic [MW-1:0]        add_mb, add_ms;
    logic [MW+2:0]        big_x, sml_x, add_sum;
    logic [2*MW-1:0]      prod;
    logic [W-1:0]         itof_mag, ft_mag, ft_res;
    logic [SW-1:0]        ft_sh;
    logic                 ft_ovf;

    always_comb begin
        x1 = $signed({3'b000, e1_q});
        x2 = $signed({3'b000, e2_q});

        a_ge     = {e1_q, m1_q} >= {e2_q, m2_q};
        add_sb   = a_ge ? s1_q : s2_q;
        add_eb   = a_ge ? e1_q : e2_q;
        add_es   = a_ge ? e2_q : e1_q;
        add_mb   = a_ge ? m1_q : m2_q;
        add_ms   = a_ge ? m2_q : m1_q;
        add_diff = add_eb - add_es;
        xb       = $signed({3'b000, add_eb});
        // Two guard bits below the mantissa plus a carry bit on top.
        big_x    = {1'b0, add_mb, 2'b00};
        sml_x    = {1'b0, add_ms, 2'b00} >> add_diff;
        add_sum  = (s1_q == s2_q) ? big_x + sml_x : big_x - sml_x;
        add_bypass = add_diff > EXP_W'(MANT_W + 2);

        prod = {{MW{1'b0}}, m1_q} * {{MW{1'b0}}, m2_q};

        itof_mag = b_q[W-1] ? -b_q : b_q;

        ft_k   = x2 - XBIAS;
        ft_sh  = SW'(m2_q) << ft_k;
        ft_mag = W'(ft_sh >> MANT_W);
        ft_res = '0;
        ft_ovf = 1'b0;
        if (e2_q == '0 || ft_k[XW-1]) begin
            ft_res = '0;
        end else if (ft_k >= XWM1) begin
            ft_res = s2_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            ft_ovf = 1'b1;
        end else begin
            ft_res = s2_q ? -ft_mag : ft_mag;
        end
    end

    // Every float result is left in acc_d with exp_d being the exponent
    // it would have if acc_d[AW-1] were the leading one.
    logic                 sgn_d, direct_d, dovf_d, dinv_d;
    logic [AW-1:0]        acc_d;
    logic signed [XW-1:0] exp_d;
    logic [W-1:0]         dres_d;

    always_comb begin
        sgn_d    = 1'b0;
        acc_d    = '0;
        exp_d    = '0;
        direct_d = 1'b0;
        dres_d   = '0;
        dovf_d   = 1'b0;
        dinv_d   = 1'b0;
        case (op_q)
            OP_ADDF, OP_SUBF: begin
                if (add_bypass) begin
                    direct_d = 1'b1;
                    dres_d   = {add_sb, add_eb, add_mb[MANT_W-1:0]};
                end else begin
                    sgn_d = add_sb;
                    acc_d = AW'(add_sum) << (AW - (MW + 3));
                    exp_d = xb + XONE;
                end
            end
            OP_MULF: begin
                sgn_d = s1_q ^ s2_q;
                acc_d = AW'(prod) << (AW - 2 * MW);
                exp_d = x1 + x2 - XBIAS + XONE;
            end
            OP_ITOF: begin
                sgn_d = b_q[W-1];
                acc_d = AW'(itof_mag) << (AW - W);
                exp_d = XBIAS + XWM1;
            end
            OP_FTOI: begin
                direct_d = 1'b1;
                dres_d   = ft_res;
                dovf_d   = ft_ovf;
            end
            default: begin
                direct_d = 1'b1;
                dinv_d   = 1'b1;
            end
        endcase
    end

    // ---------------- normalise ----------------
    logic [LZW-1:0]       lz;
    logic [MW-1:0]        nman_d;
    logic signed [XW-1:0] nexp_d;

    always_comb begin
        lz     = lzc(acc_q);
        nman_d = MW'((acc_q << lz) >> (AW - MW));
        nexp_d = exp_q - $signed({{(XW-LZW){1'b0}}, lz});
    end

    // ---------------- pack ----------------
    logic [W-1:0] pk_res;
    logic         pk_ovf, pk_inv;

    always_comb begin
        pk_res = '0;
        pk_ovf = 1'b0;
        pk_inv = 1'b0;
        if (direct_q) begin
            pk_res = dres_q;
            pk_ovf = dovf_q;
            pk_inv = dinv_q;
        end else if (!nman_q[MW-1] || nexp_q[XW-1] || nexp_q == '0) begin
            pk_res = '0;
        end else if (nexp_q >= XEMAX) begin
            pk_res = {sgn_q, EXP_W'(EMAX - 1), {MANT_W{1'b1}}};
            pk_ovf = 1'b1;
        end else begin
            pk_res = {sgn_q, nexp_q[EXP_W-1:0], nman_q[MANT_W-1:0]};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            e1_q     <= '0;
            e2_q     <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            sgn_q    <= 1'b0;
            acc_q    <= '0;
            exp_q    <= '0;
            direct_q <= 1'b0;
            dres_q   <= '0;
            dovf_q   <= 1'b0;
            dinv_q   <= 1'b0;
            nman_q   <= '0;
            nexp_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= op1;
                        b_q     <= op2;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        inv_q   <= 1'b0;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    s1_q    <= a_q[W-1];
                    s2_q    <= u_s2;
                    e1_q    <= u_e1;
                    e2_q    <= u_e2;
                    m1_q    <= u_m1;
                    m2_q    <= u_m2;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    sgn_q    <= sgn_d;
                    acc_q    <= acc_d;
                    exp_q    <= exp_d;
                    direct_q <= direct_d;
                    dres_q   <= dres_d;
                    dovf_q   <= dovf_d;
                    dinv_q   <= dinv_d;
                    state_q  <= S_NORM;
                end
                S_NORM: begin
                    nman_q  <= nman_d;
                    nexp_q  <= nexp_d;
                    state_q <= S_PACK;
                end
                S_PACK: begin
                    result_q <= pk_res;
                    ovf_q    <= pk_ovf;
                    inv_q    <= pk_inv;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mc.sv
// tb_fpu_mc: directed vectors for fpu_mc with a queue-based scoreboard.
// A negedge monitor pops one expectation per done pulse.
module tb_fpu_mc;

    localparam logic [4:0] ITOF = 5'b10010;
    localparam logic [4:0] FTOI = 5'b10011;
    localparam logic [4:0] MULF = 5'b10101;
    localparam logic [4:0] SUBF = 5'b10110;
    localparam logic [4:0] ADDF = 5'b10111;

    logic        clk, reset, start;
    logic [4:0]  op;
    logic [15:0] op1, op2, result;
    logic        busy, done, ovf, inv;

    fpu_mc dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .inv    (inv)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        ovf;
        logic        inv;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_result"}, 32'(result), 32'(e.res));
                chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
                chk({e.name, "_inv"}, 32'(inv), 32'(e.inv));
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd4);
            end
        end
    end

    // Called at a negedge; the request is taken on the next rising edge.
    task automatic issue(input string nm, input logic [4:0] o,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic ov,
                         input logic iv);
        exp_t e;
        e.name = nm;
        e.res  = r;
        e.ovf  = ov;
        e.inv  = iv;
        e.acc  = cyc + 1;
        sbq.push_back(e);
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done never rose within 12 cycles", nm);
        end
    endtask

    task automatic run(input string nm, input logic [4:0] o,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic ov,
                       input logic iv);
        issue(nm, o, a, b, r, ov, iv);
        wait_done(nm);
        @(negedge clk);
    endtask

    initial begin
        int saw;
        int n;
        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_inv", 32'(inv), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run("itof_1",    ITOF, 16'h0000, 16'h0001, 16'h3F80, 1'b0, 1'b0);
        run("itof_m5",   ITOF, 16'h0000, 16'hFFFB, 16'hC0A0, 1'b0, 1'b0);
        run("itof_0",    ITOF, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run("itof_min",  ITOF, 16'h0000, 16'h8000, 16'hC700, 1'b0, 1'b0);
        run("addf_1_2",  ADDF, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 1'b0);
        run("subf_zero", SUBF, 16'h3F80, 16'h3F80, 16'h0000, 1'b0, 1'b0);
        run("subf_neg",  SUBF, 16'h3F80, 16'h4000, 16'hBF80, 1'b0, 1'b0);
        run("addf_trunc",ADDF, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0, 1'b0);
        run("addf_guard",ADDF, 16'h3F80, 16'h3C00, 16'h3F81, 1'b0, 1'b0);
        run("addf_byp",  ADDF, 16'h4B00, 16'h3F80, 16'h4B00, 1'b0, 1'b0);
        run("subf_byp",  SUBF, 16'h3F80, 16'h4B00, 16'hCB00, 1'b0, 1'b0);
        run("mulf_2_3",  MULF, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0);
        run("mulf_neg",  MULF, 16'hC000, 16'h4040, 16'hC0C0, 1'b0, 1'b0);
        run("mulf_sat",  MULF, 16'h7F00, 16'h7F00, 16'h7F7F, 1'b1, 1'b0);
        run("mulf_flush",MULF, 16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b0);
        run("ftoi_m5",   FTOI, 16'h0000, 16'hC0A0, 16'hFFFB, 1'b0, 1'b0);
        run("ftoi_3",    FTOI, 16'h0000, 16'h4040, 16'h0003, 1'b0, 1'b0);
        run("ftoi_big",  FTOI, 16'h0000, 16'h4780, 16'h7FFF, 1'b1, 1'b0);
        run("ftoi_nbig", FTOI, 16'h0000, 16'hC780, 16'h8000, 1'b1, 1'b0);
        run("ftoi_2p14", FTOI, 16'h0000, 16'h4680, 16'h4000, 1'b0, 1'b0);
        run("ftoi_half", FTOI, 16'h0000, 16'h3F00, 16'h0000, 1'b0, 1'b0);

        // start while busy must be ignored
        issue("ign_a", ITOF, 16'h0000, 16'h0007, 16'h40E0, 1'b0, 1'b0);
        op    = ADDF;
        op1   = 16'h4000;
        op2   = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_a");
        repeat (6) @(negedge clk);
        chk("ign_hold", 32'(result), 32'h40E0);

        // second request raised in the done cycle
        issue("b2b_a", ADDF, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 1'b0);
        wait_done("b2b_a");
        issue("b2b_b", MULF, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0);
        wait_done("b2b_b");
        @(negedge clk);

        // reset while in EXEC aborts with no done
        issue("rst_a", ITOF, 16'h0000, 16'h0003, 16'h4040, 1'b0, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        void'(sbq.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("abort_nodone", 32'(saw), 32'd0);
        run("post_rst", ITOF, 16'h0000, 16'h0001, 16'h3F80, 1'b0, 1'b0);

        run("badop", 5'b00000, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never completed", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_mc.md
FPU_MC -- requirements
Module: fpu_mc

Interface
REQ-001 SHALL take parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL take parameter MANT_W, default 7, stored mantissa width; hidden leading 1.
REQ-003 SHALL take parameter BIAS, default 2^(EXP_W-1)-1 (127), exponent bias.
REQ-004 SHALL derive local W = 1+EXP_W+MANT_W (16) and lay out a word as {sign, exp, mant}, MSB first.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  single-cycle request, sampled only when busy=0.
REQ-008 SHALL have port op  input  5  opcode: itof 10010, ftoi 10011, mulf 10101, subf 10110, addf 10111.
REQ-009 SHALL have ports op1 and op2  input  W  operands: op1 first, op2 second; itof/ftoi use op2 only.
REQ-010 SHALL have port result  output  W  result register, held until the next accepted start.
REQ-011 SHALL have port busy  output  1  high from the edge that accepts start until the edge that raises done.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports ovf and inv  output  1 each  saturation flag and invalid-opcode flag, valid while done=1, held until the next start.

Function
REQ-014 SHALL implement FSM IDLE->UNPACK->EXEC->NORM->PACK->IDLE, one state per clock.
REQ-015 SHALL, on the rising edge where start=1 in IDLE, latch op, op1 and op2, set busy=1 and enter UNPACK; done SHALL be 1 exactly 4 clocks after that edge, for one cycle.
REQ-016 SHALL ignore start while busy=1; latched operands SHALL NOT change.
REQ-017 SHALL accept a start asserted in the same cycle as done=1, giving back-to-back operation with no idle cycle.
REQ-018 SHALL treat exp field 0 as value zero regardless of mantissa; no denormals, infinities or NaNs exist.
REQ-019 SHALL truncate (round toward zero) in every operation.
REQ-020 itof: SHALL treat op2 as W-bit two's complement; 0 -> 0x0000; otherwise take the magnitude, find the leading one with a leading-zero count, set exp = BIAS+msb_index, and form mant from the bits below the leading one.
REQ-021 ftoi: SHALL return trunc(op2) as W-bit two's complement; |value|<1 -> 0; if |value| >= 2^(W-1), return 0x7FFF (positive) or 0x8000 (negative) and set ovf=1.
REQ-022 addf/subf: SHALL invert the sign of op2 for subf, align the smaller-exponent operand right by the exponent difference, and keep 2 guard bits, discarded at pack.
REQ-023 addf/subf: SHALL return the larger operand unchanged when the exponent difference exceeds MANT_W+2.
REQ-024 addf/subf: SHALL return +0 (0x0000) on exact cancellation, and SHALL renormalise left by the leading-zero count or right by 1 on carry-out.
REQ-025 mulf: SHALL set sign = s1^s2, form exp = e1+e2-BIAS, and take the (MANT_W+1)x(MANT_W+1) product normalised by at most 1 bit; either operand zero -> +0.
REQ-026 SHALL flush to +0 when the final exp <= 0, with ovf=0.
REQ-027 SHALL, when the final exp >= 2^EXP_W-1, saturate to sign with max finite (exp=2^EXP_W-2, mant all ones) and set ovf=1.
REQ-028 SHALL complete an unlisted opcode with the same 4-cycle latency, result=0 and inv=1.

Reset
REQ-029 SHALL, while reset=0, force FSM=IDLE, busy=0, done=0, result=0, ovf=0 and inv=0 immediately, independent of clk.
REQ-030 SHALL abort an in-flight operation on reset; no done pulse SHALL follow; the first start after reset release SHALL be accepted normally.

Verification
REQ-031 SHALL cover itof: op2=0x0001 -> 0x3F80; op2=0xFFFB -> 0xC0A0; op2=0 -> 0x0000; each with done exactly 4 clocks after start.
REQ-032 SHALL cover arithmetic: addf 0x3F80+0x4000 -> 0x4040; subf 0x3F80-0x3F80 -> 0x0000; mulf 0x4000*0x4040 -> 0x40C0.
REQ-033 SHALL cover ftoi: 0xC0A0 -> 0xFFFB with ovf=0; 0x4780 (2^16) -> 0x7FFF with ovf=1; 0x3F00 (0.5) -> 0x0000.
REQ-034 SHALL cover saturation and flush: mulf 0x7F00*0x7F00 -> 0x7F7F with ovf=1; mulf 0x0080*0x0080 -> 0x0000.
REQ-035 SHALL cover the handshake: start pulsed while busy -> ignored, original result kept; start in the done cycle -> second done exactly 4 clocks later.
REQ-036 SHALL cover reset and bad opcode: reset low during EXEC -> busy=0 and result=0 at once, no done; op=00000 -> done after 4 clocks with inv=1 and result=0.
